// File: rtl/uart_line_window.sv
// uart_line_window: line assembler ahead of the command matcher.
// Collects printable characters from the UART byte stream into a
// CHARACTER_COUNT-character window. Backspace removes the newest character.
// A terminator presents the window as a frame, but only when the window is
// exactly full. Short or over-long lines are discarded with a line_drop pulse.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   rx_data      received byte
//   rx_valid     one-cycle strobe qualifying rx_data (no backpressure)
//   sr_data      window; newest char in the low byte, first char of line on top
//   frame_valid  window holds a complete line, sr_data stable while high
//   frame_ready  consumer accepts the presented frame
//   char_count   number of characters currently in the window
//   line_drop    one-cycle pulse, a terminated line was discarded
//   overrun      sticky, a byte arrived while a frame was pending
//   clear_errors synchronous clear of overrun (a same-cycle set wins)
module uart_line_window #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned CHARACTER_COUNT = 10
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [DATA_WIDTH-1:0]                 rx_data,
    input  logic                                  rx_valid,
    output logic [DATA_WIDTH*CHARACTER_COUNT-1:0] sr_data,
    output logic                                  frame_valid,
    input  logic                                  frame_ready,
    output logic [$clog2(CHARACTER_COUNT+1)-1:0]  char_count,
    output logic                                  line_drop,
    output logic                                  overrun,
    input  logic                                  clear_errors
);

    localparam int unsigned WIN_W = DATA_WIDTH * CHARACTER_COUNT;
    localparam int unsigned CNT_W = $clog2(CHARACTER_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHARACTER_COUNT);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [DATA_WIDTH-1:0] CH_SPACE = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0] CH_TILDE = DATA_WIDTH'(8'h7E);
    localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] CH_LF    = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CH_BS    = DATA_WIDTH'(8'h08);
    localparam logic [DATA_WIDTH-1:0] CH_DEL   = DATA_WIDTH'(8'h7F);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t state;
    logic   long_line;  // line overflowed the window; held until its terminator

    logic is_print_c;
    logic is_term_c;
    logic is_bs_c;
    logic full_c;
    logic empty_c;

    // Byte classification; anything outside these classes is ignored.
    always_comb begin
        is_print_c = (rx_data >= CH_SPACE) && (rx_data <= CH_TILDE);
        is_term_c  = (rx_data == CH_CR) || (rx_data == CH_LF);
        is_bs_c    = (rx_data == CH_BS) || (rx_data == CH_DEL);
        full_c     = (char_count == CNT_FULL);
        empty_c    = (char_count == CNT_ZERO);
    end

    // Line FSM, window shift register and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= COLLECT;
            sr_data     <= '0;
            char_count  <= '0;
            frame_valid <= 1'b0;
            line_drop   <= 1'b0;
            overrun     <= 1'b0;
            long_line   <= 1'b0;
        end else begin
            line_drop <= 1'b0;

            // Clear first so that a simultaneous overrun set takes priority.
            if (clear_errors) begin
                overrun <= 1'b0;
            end
            if ((state == PRESENT) && rx_valid) begin
                overrun <= 1'b1;
            end

            case (state)
                COLLECT: begin
                    if (rx_valid) begin
                        if (is_print_c) begin
                            if (!full_c) begin
                                sr_data    <= {sr_data[WIN_W-DATA_WIDTH-1:0], rx_data};
                                char_count <= char_count + CNT_ONE;
                            end else begin
                                long_line <= 1'b1;
                            end
                        end else if (is_bs_c) begin
                            if (!long_line && !empty_c) begin
                                sr_data    <= {{DATA_WIDTH{1'b0}}, sr_data[WIN_W-1:DATA_WIDTH]};
                                char_count <= char_count - CNT_ONE;
                            end
                        end else if (is_term_c) begin
                            // An empty line is the second half of CRLF: ignore it.
                            if (empty_c && !long_line) begin
                                state <= COLLECT;
                            end else if (full_c && !long_line) begin
                                state       <= PRESENT;
                                frame_valid <= 1'b1;
                            end else begin
                                line_drop  <= 1'b1;
                                sr_data    <= '0;
                                char_count <= '0;
                                long_line  <= 1'b0;
                            end
                        end
                    end
                end

                PRESENT: begin
                    // Window is frozen; incoming bytes only raise overrun.
                    if (frame_ready) begin
                        state       <= COLLECT;
                        frame_valid <= 1'b0;
                        sr_data     <= '0;
                        char_count  <= '0;
                    end
                end

                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_line_window.sv
// Self-checking bench for uart_line_window: a queue-based line model is
// compared against the DUT on every falling edge, and directed literal
// checks pin the model at the points the behaviour is defined by hand.
module tb_uart_line_window;

    localparam int unsigned DW = 8;
    localparam int unsigned CC = 10;
    localparam int unsigned WW = DW * CC;
    localparam int unsigned CW = $clog2(CC + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [WW-1:0] sr_data;
    logic          frame_valid;
    logic          frame_ready = 1'b1;
    logic [CW-1:0] char_count;
    logic          line_drop;
    logic          overrun;
    logic          clear_errors = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int frames   = 0;

    uart_line_window #(.DATA_WIDTH(DW), .CHARACTER_COUNT(CC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .sr_data      (sr_data),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .char_count   (char_count),
        .line_drop    (line_drop),
        .overrun      (overrun),
        .clear_errors (clear_errors)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned m_line[$];
    bit           m_long;
    bit           m_pending;
    bit           m_drop;
    bit           m_ovr;

    function automatic logic [WW-1:0] m_window();
        logic [WW-1:0] v = '0;
        foreach (m_line[i]) v = {v[WW-DW-1:0], m_line[i]};
        return v;
    endfunction

    task automatic m_reset();
        m_line.delete();
        m_long = 0; m_pending = 0; m_drop = 0; m_ovr = 0;
    endtask

    task automatic m_step(input byte unsigned b, input bit v, input bit rdy, input bit clr);
        bit pr, te, bs;
        pr = (b >= 8'h20) && (b <= 8'h7E);
        te = (b == 8'h0D) || (b == 8'h0A);
        bs = (b == 8'h08) || (b == 8'h7F);
        m_drop = 0;
        if (clr) m_ovr = 0;
        if (m_pending) begin
            if (v) m_ovr = 1;
            if (rdy) begin
                m_pending = 0;
                m_line.delete();
            end
        end else if (v) begin
            if (pr) begin
                if (m_line.size() < CC) m_line.push_back(b);
                else m_long = 1;
            end else if (bs) begin
                if (!m_long && m_line.size() > 0) void'(m_line.pop_back());
            end else if (te) begin
                if (m_line.size() == 0 && !m_long) begin
                    // CRLF tail
                end else if (m_line.size() == CC && !m_long) begin
                    m_pending = 1;
                end else begin
                    m_drop = 1;
                    m_line.delete();
                    m_long = 0;
                end
            end
        end
    endtask

    // Compare process: check outputs against the model, then advance the
    // model with the inputs the DUT will sample on the next rising edge.
    always @(negedge clk) begin
        if (!reset_n) m_reset();
        check("sr_data", sr_data, m_window());
        check("frame_valid", WW'(frame_valid), WW'(m_pending));
        check("char_count", WW'(char_count), WW'(m_line.size()));
        check("line_drop", WW'(line_drop), WW'(m_drop));
        check("overrun", WW'(overrun), WW'(m_ovr));
        if (frame_valid && frame_ready) frames++;
        if (reset_n) m_step(rx_data, rx_valid, frame_ready, clear_errors);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input byte unsigned b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    localparam logic [WW-1:0] L_SW    = "SW: 0x1A2F";
    localparam logic [WW-1:0] L_DIG   = "0123456789";
    localparam logic [WW-1:0] L_HELLO = "HELLOWORLD";
    localparam logic [WW-1:0] L_CLEAN = "CLEANLINE!";

    initial begin
        // Reset state
        tick(2);
        check("rst_sr", sr_data, '0);
        check("rst_fv", WW'(frame_valid), '0);
        check("rst_cnt", WW'(char_count), '0);
        check("rst_ovr", WW'(overrun), '0);
        check("rst_drop", WW'(line_drop), '0);
        reset_n = 1'b1;
        tick(1);

        // Ignored bytes on an empty window
        send(8'h08); send(8'h01); send(8'h0D);
        check("ign_cnt", WW'(char_count), '0);

        // Basic frame, CR then LF after one idle cycle
        send_str("SW: 0x1A2F");
        send(8'h0D);
        check("sw_fv", WW'(frame_valid), WW'(1));
        check("sw_sr", sr_data, L_SW);
        check("sw_cnt", WW'(char_count), WW'(10));
        tick(1);
        send(8'h0A);
        tick(2);
        check("sw_fv_lo", WW'(frame_valid), '0);
        check("sw_cnt0", WW'(char_count), '0);
        check("sw_frames", WW'(frames), WW'(1));
        check("sw_ovr", WW'(overrun), '0);

        // Backspace edit
        send_str("SW: 0x1A2X");
        send(8'h08);
        check("bs_cnt", WW'(char_count), WW'(9));
        send_str("F");
        send(8'h0D);
        check("bs_sr", sr_data, L_SW);
        check("bs_cnt10", WW'(char_count), WW'(10));
        check("bs_fv", WW'(frame_valid), WW'(1));
        tick(1);

        // Short line
        send_str("SW: 0x1");
        send(8'h0A);
        check("short_drop", WW'(line_drop), WW'(1));
        check("short_fv", WW'(frame_valid), '0);
        check("short_sr", sr_data, '0);
        check("short_cnt", WW'(char_count), '0);
        tick(1);
        check("short_drop_lo", WW'(line_drop), '0);

        // Long line then a good line
        send_str("ABCDEFGHIJKL");
        send(8'h08);
        check("long_cnt", WW'(char_count), WW'(10));
        send(8'h0D);
        check("long_drop", WW'(line_drop), WW'(1));
        check("long_cnt0", WW'(char_count), '0);
        send_str("0123456789");
        send(8'h0D);
        check("after_long_fv", WW'(frame_valid), WW'(1));
        check("after_long_sr", sr_data, L_DIG);
        tick(1);

        // Overrun while frame pending
        frame_ready = 1'b0;
        send_str("HELLOWORLD");
        send(8'h0D);
        tick(1);
        check("hold_fv", WW'(frame_valid), WW'(1));
        send_str("A");
        check("ovr_set", WW'(overrun), WW'(1));
        check("ovr_sr", sr_data, L_HELLO);
        check("ovr_fv", WW'(frame_valid), WW'(1));
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        check("ovr_clr", WW'(overrun), '0);
        clear_errors = 1'b1;
        send_str("B");
        clear_errors = 1'b0;
        check("ovr_set_wins", WW'(overrun), WW'(1));

        // Asynchronous reset during PRESENT
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_fv", WW'(frame_valid), '0);
        check("arst_sr", sr_data, '0);
        check("arst_cnt", WW'(char_count), '0);
        check("arst_ovr", WW'(overrun), '0);
        tick(1);
        reset_n = 1'b1;
        frame_ready = 1'b1;
        tick(1);
        send_str("CLEANLINE!");
        send(8'h0D);
        check("clean_fv", WW'(frame_valid), WW'(1));
        check("clean_sr", sr_data, L_CLEAN);
        tick(2);
        check("clean_done", WW'(frame_valid), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_line_window.md
Name: uart_line_window

Overview:
- Upstream stage of the command-matcher: consumes the received UART byte stream and maintains a CHARACTER_COUNT-character window.
- On a line terminator, presents a complete, exactly-full window as a frame. The frame holds the flat sr_data bus plus a frame_valid strobe, and the matcher uses frame_valid as its ena.
- Edits (backspace), short lines, long lines and overruns are resolved here, so the matcher only ever sees clean, full-length lines.

Parameters:
- DATA_WIDTH, 8, bits per character.
- CHARACTER_COUNT, 10, window length in characters; a frame must be exactly this long.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- rx_data  input  DATA_WIDTH  received byte from UART receiver
- rx_valid  input  1  one-cycle strobe, rx_data valid this cycle; no backpressure possible
- sr_data  output  DATA_WIDTH*CHARACTER_COUNT  window; newest char at [DATA_WIDTH-1:0], oldest (first of line) at top byte
- frame_valid  output  1  window holds a complete line; sr_data stable while high
- frame_ready  input  1  consumer accepts frame (tie high for fire-and-forget)
- char_count  output  $clog2(CHARACTER_COUNT+1)  characters currently in window
- line_drop  output  1  one-cycle pulse, a terminated line was discarded (short or long)
- overrun  output  1  sticky, byte arrived while a frame was pending
- clear_errors  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, reset_n=0): sr_data=0, char_count=0, frame_valid=0, line_drop=0, overrun=0, long flag=0, state=COLLECT.
- Byte classes:
  - printable 0x20..0x7E
  - terminator 0x0D/0x0A
  - backspace 0x08/0x7F
  - all others ignored with no state change
- State COLLECT, rx_valid=1:
  - Printable, char_count<CHARACTER_COUNT: shift window up one byte, insert byte at bottom, char_count+1.
  - Printable, char_count==CHARACTER_COUNT: set internal long flag; window and count unchanged; further printables ignored until terminator.
  - Backspace, long flag=0 and char_count>0: shift window down one byte (top byte <= 0), char_count-1.
  - Backspace with char_count==0 or long flag=1: ignored.
  - Terminator, char_count==0 and long flag=0: ignored, so CRLF yields one frame.
  - Terminator, char_count==CHARACTER_COUNT and long flag=0: go PRESENT. frame_valid=1 from the next cycle (latency 1 clock from the terminator strobe).
  - Terminator, otherwise (short or long): line_drop pulses for 1 cycle next cycle; window cleared to 0; char_count=0; long flag=0; stay COLLECT.
- State PRESENT:
  - frame_valid=1; sr_data and char_count frozen.
  - frame_ready=1: next cycle frame_valid=0, window cleared to 0, char_count=0, state=COLLECT.
  - frame_valid must remain high until frame_ready is seen; a frame is presented for at least one cycle.
  - rx_valid=1 (any class, including the same cycle as frame_ready): byte dropped, overrun set.
- Overrun:
  - clear_errors=1 clears overrun.
  - If set and clear occur in the same cycle, set wins.
- Reset asserted mid-line or mid-PRESENT: immediate return to reset values; the pending frame is lost and no line_drop is issued.
- char_count never exceeds CHARACTER_COUNT and never underflows.

Test Plan:
- Send "SW: 0x1A2F" then 0x0D, 0x0A:
  - frame_valid=1 the cycle after the CR strobe; sr_data = {"S","W",":"," ","0","x","1","A","2","F"}.
  - With frame_ready=1, exactly one frame; the LF is ignored; char_count returns to 0.
- Send "SW: 0x1A2X", 0x08, "F", 0x0D -> frame sr_data reads "SW: 0x1A2F"; char_count=10 while frame_valid.
- Send "SW: 0x1", 0x0A -> line_drop single pulse, no frame_valid, sr_data=0, char_count=0.
- Send 12 printables then 0x0D -> no frame, line_drop pulse, long flag cleared. A following valid 10-char line frames normally.
- Hold frame_ready=0 after a frame, send "A":
  - overrun=1; sr_data unchanged; frame_valid stays 1.
  - clear_errors pulse clears overrun.
  - clear_errors coincident with a new byte leaves overrun=1.
- Assert reset_n=0 asynchronously (between clock edges) during PRESENT -> frame_valid, sr_data, char_count, overrun all 0 immediately; the next clean line frames correctly.
